inv_mix_columns_ctrl: RTL

Sequencing controller for the InvMixColumns step of the AES-128 decryption round. It accepts one 128-bit state over a valid/ready handshake and processes it one column per cycle through a shared bank of registered GF(2^8) constant-multiplier LUTs (×9, ×11, ×13, ×14). It then presents the transformed state over a second valid/ready handshake. A bypass input lets the final decryption round skip the transform without changing the datapath wiring.

---
 rtl/inv_mix_columns_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/inv_mix_columns_ctrl.sv
// AES-128 InvMixColumns sequencer: one column per cycle through a shared bank of
// registered GF(2^8) constant-multiplier LUTs, with valid/ready on both sides.

module gf_const_lut #(
    parameter logic [7:0] K = 8'h01
) (
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] data
);
    logic [7:0] data_d;
    logic [7:0] data_q;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    always_comb data_d = gf_mul(addr, K);

    // Table read is registered; contents are don't-care until consumed, so no reset.
    always_ff @(posedge clk) data_q <= data_d;

    assign data = data_q;
endmodule

module lut_mult_9 (
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] data
);
    gf_const_lut #(.K(8'd9)) u_lut (.clk(clk), .addr(addr), .data(data));
endmodule

module lut_mult_11 (
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] data
);
    gf_const_lut #(.K(8'd11)) u_lut (.clk(clk), .addr(addr), .data(data));
endmodule

module lut_mult_13 (
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] data
);
    gf_const_lut #(.K(8'd13)) u_lut (.clk(clk), .addr(addr), .data(data));
endmodule

module lut_mult_14 (
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] data
);
    gf_const_lut #(.K(8'd14)) u_lut (.clk(clk), .addr(addr), .data(data));
endmodule

module inv_mix_columns_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bypass,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int unsigned NROW = 4;
    localparam int unsigned CW   = 32;
    localparam int unsigned SW   = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [SW-1:0] in_q, in_d;
    logic [SW-1:0] result_q, result_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;

    logic [CW-1:0] col_word;
    logic [CW-1:0] comb_word;
    logic [7:0]    lut_addr [NROW];
    logic [7:0]    m9       [NROW];
    logic [7:0]    m11      [NROW];
    logic [7:0]    m13      [NROW];
    logic [7:0]    m14      [NROW];
    logic          wr_en;
    logic [1:0]    wr_col;
    logic          load;

    // Column currently addressing the multiplier bank.
    always_comb begin
        case (col_q)
            2'd0:    col_word = in_q[127:96];
            2'd1:    col_word = in_q[95:64];
            2'd2:    col_word = in_q[63:32];
            default: col_word = in_q[31:0];
        endcase
        for (int r = 0; r < NROW; r++) begin
            lut_addr[r] = col_word[31-8*r -: 8];
        end
    end

    for (genvar r = 0; r < NROW; r++) begin : g_bank
        lut_mult_9  u_m9  (.clk(clk), .addr(lut_addr[r]), .data(m9[r]));
        lut_mult_11 u_m11 (.clk(clk), .addr(lut_addr[r]), .data(m11[r]));
        lut_mult_13 u_m13 (.clk(clk), .addr(lut_addr[r]), .data(m13[r]));
        lut_mult_14 u_m14 (.clk(clk), .addr(lut_addr[r]), .data(m14[r]));
    end

    // Inverse MixColumns matrix applied to the previous column's LUT outputs.
    always_comb begin
        comb_word[31:24] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
        comb_word[23:16] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
        comb_word[15:8]  = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
        comb_word[7:0]   = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        in_d     = in_q;
        result_d = result_q;
        wr_en    = 1'b0;
        wr_col   = col_q;
        load     = 1'b0;
        in_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
            end
            ST_ISSUE: begin
                wr_en  = (col_q != 2'd0);
                wr_col = 2'(col_q - 2'd1);
                col_d  = 2'(col_q + 2'd1);
                if (col_q == 2'd3) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                wr_en   = 1'b1;
                wr_col  = 2'd3;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // Handoff and a new accept can share the same edge.
                in_ready = out_ready;
                if (out_ready) begin
                    state_d = ST_IDLE;
                    load    = in_valid;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            in_d  = in_state;
            col_d = 2'd0;
            if (in_bypass) begin
                result_d = in_state;
                state_d  = ST_DONE;
            end else begin
                state_d = ST_ISSUE;
            end
        end

        for (int c = 0; c < NROW; c++) begin
            if (wr_en && (wr_col == 2'(c))) result_d[127-32*c -: 32] = comb_word;
        end

        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            col_q       <= 2'd0;
            in_q        <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            in_q        <= in_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = result_q;
    assign busy      = busy_q;
endmodule
